// File: rtl/dma_desc_scheduler.sv
// Descriptor queue plus register sequencer that programs the DMA engine once per copy job.
// Define DMA_SCHED_TIMEOUT_EN to add a WAIT watchdog (TIMEOUT_CYCLES) with a sticky err flag.
//
// state  | meaning
// IDLE   | no job in service; starts the head job when the queue is non-empty
// W_SRC  | write src_base (word 0)
// W_DST  | write dest_base (word 1)
// W_SIZE | write dma_size (word 4)
// W_TAIL | write tail_ptr = 0 (word 2)
// W_HEAD | write head_ptr = size (word 3)
// W_CTRL | write ctrl_stat = EN (word 5)
// WAIT   | engine running; watch dma_intr with ctrl_stat.INTR
// CLR    | write ctrl_stat = 0, clearing INTR and EN
// POP    | retire the head job
module dma_desc_scheduler #(
    parameter int ADDR_WIDTH     = 12,
    parameter int QDEPTH_LOG2    = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESET,
    input  logic [31:0]             desc_src,
    input  logic [31:0]             desc_dest,
    input  logic [31:0]             desc_size,
    input  logic                    desc_valid,
    output logic                    desc_ready,
    output logic [ADDR_WIDTH-3:0]   reg_addr,
    output logic [31:0]             reg_wdata,
    output logic                    reg_write,
    input  logic [31:0]             reg_rdata,
    input  logic                    dma_intr,
    output logic                    busy,
    output logic [QDEPTH_LOG2:0]    q_level,
    output logic [15:0]             done_cnt,
    output logic                    err
);
    localparam int DEPTH = 1 << QDEPTH_LOG2;
    localparam int AW    = ADDR_WIDTH - 2;
    localparam int PW    = QDEPTH_LOG2;
    localparam int CW    = QDEPTH_LOG2 + 1;

    typedef enum logic [3:0] {
        IDLE, W_SRC, W_DST, W_SIZE, W_TAIL, W_HEAD, W_CTRL, WAIT, CLR, POP
    } state_t;

    state_t         state;
    logic [31:0]    q_src  [DEPTH];
    logic [31:0]    q_dest [DEPTH];
    logic [31:0]    q_size [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;
    logic [31:0]    head_src;
    logic [31:0]    head_dest;
    logic [31:0]    head_size_m;

    assign desc_ready  = (count != CW'(DEPTH));
    assign push        = desc_valid & desc_ready;
    assign pop         = (state == POP);
    assign q_level     = count;
    assign busy        = (state != IDLE);
    assign head_src    = q_src[rd_ptr];
    assign head_dest   = q_dest[rd_ptr];
    assign head_size_m = q_size[rd_ptr] & ~32'h3;

    // Only the INTR bit of ctrl_stat is ever inspected.
    logic unused_rdata;
    assign unused_rdata = ^reg_rdata[30:0];

    always_ff @(posedge M_AXI_ACLK) begin
        if (push) begin
            q_src[wr_ptr]  <= desc_src;
            q_dest[wr_ptr] <= desc_dest;
            q_size[wr_ptr] <= desc_size;
        end
    end

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]  timer;
    logic           timed_out;
    logic           err_q;
    assign err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
    assign err        = 1'b0;
`endif

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            done_cnt <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
            timer     <= '0;
            timed_out <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        if (head_size_m == '0)
                            state <= POP;
                        else
                            state <= W_SRC;
                    end
                end
                W_SRC:  state <= W_DST;
                W_DST:  state <= W_SIZE;
                W_SIZE: state <= W_TAIL;
                W_TAIL: state <= W_HEAD;
                W_HEAD: state <= W_CTRL;
                W_CTRL: begin
                    state <= WAIT;
`ifdef DMA_SCHED_TIMEOUT_EN
                    timer <= TW'(TIMEOUT_CYCLES - 1);
`endif
                end
                WAIT: begin
                    if (dma_intr && reg_rdata[31])
                        state <= CLR;
`ifdef DMA_SCHED_TIMEOUT_EN
                    else if (timer == '0) begin
                        state     <= CLR;
                        timed_out <= 1'b1;
                        err_q     <= 1'b1;
                    end else
                        timer <= timer - TW'(1);
`endif
                end
                CLR: state <= POP;
                POP: begin
                    state <= IDLE;
`ifdef DMA_SCHED_TIMEOUT_EN
                    timed_out <= 1'b0;
                    if (!timed_out)
                        done_cnt <= done_cnt + 16'd1;
`else
                    done_cnt <= done_cnt + 16'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        reg_write = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        case (state)
            W_SRC:  begin reg_write = 1'b1; reg_addr = AW'(0); reg_wdata = head_src;    end
            W_DST:  begin reg_write = 1'b1; reg_addr = AW'(1); reg_wdata = head_dest;   end
            W_SIZE: begin reg_write = 1'b1; reg_addr = AW'(4); reg_wdata = head_size_m; end
            W_TAIL: begin reg_write = 1'b1; reg_addr = AW'(2); end
            W_HEAD: begin reg_write = 1'b1; reg_addr = AW'(3); reg_wdata = head_size_m; end
            W_CTRL: begin reg_write = 1'b1; reg_addr = AW'(5); reg_wdata = 32'h1;       end
            WAIT:   reg_addr = AW'(5);
            CLR:    begin reg_write = 1'b1; reg_addr = AW'(5); end
            default: ;
        endcase
    end
endmodule

// File: doc/dma_desc_scheduler.md
Name: dma_desc_scheduler

Overview:
- Descriptor-driven sequencer for the DMA engine's register port.
- Accepts copy jobs (src, dest, size) into a small internal queue.
- For each job: programs the engine registers in a fixed order, enables the engine, waits for its interrupt, then acknowledges it and retires the job.
- Sits between the CPU-side job source and the engine's reg_addr/reg_wdata/reg_write/reg_rdata/intr pins, replacing software register pokes.

Parameters:
- ADDR_WIDTH, 12, engine register-space byte address width; reg_addr is ADDR_WIDTH-2 bits (word index).
- QDEPTH_LOG2, 2, log2 of descriptor queue depth (default 4 entries).
- TIMEOUT_CYCLES, 65536, WAIT-state watchdog limit; used only with the optional feature.

Ports:
- M_AXI_ACLK  input  1  clock
- M_AXI_ARESET  input  1  reset, synchronous, active-high
- desc_src  input  32  job source base address
- desc_dest  input  32  job destination base address
- desc_size  input  32  job length in bytes
- desc_valid  input  1  job offered
- desc_ready  output  1  queue not full; job accepted on desc_valid&desc_ready
- reg_addr  output  ADDR_WIDTH-2  engine register word index
- reg_wdata  output  32  engine register write data
- reg_write  output  1  engine register write strobe, one cycle per write
- reg_rdata  input  32  engine register read data (combinational from reg_addr)
- dma_intr  input  1  engine interrupt, level
- busy  output  1  FSM not in IDLE
- q_level  output  QDEPTH_LOG2+1  queued job count, including the job in service
- done_cnt  output  16  retired job counter, wraps
- err  output  1  sticky timeout flag (optional feature)

Behaviour:
- Engine register map (word index): 0 src_base, 1 dest_base, 2 tail_ptr, 3 head_ptr, 4 dma_size, 5 ctrl_stat.
- ctrl_stat bits: bit0 EN, bit31 INTR.
- Reset values: all outputs 0, except desc_ready=1. State=IDLE, queue empty.
- Queue:
  - Synchronous FIFO of {src, dest, size}.
  - Head entry stays resident until the POP state.
  - Push and pop in the same cycle: q_level unchanged; a push while full is impossible because desc_ready=0.
- FSM states: IDLE, W_SRC, W_DST, W_SIZE, W_TAIL, W_HEAD, W_CTRL, WAIT, CLR, POP.
- Outputs are decoded only from the registered state plus the queue head, so there are no combinational paths from desc_* inputs to reg_* outputs.
- IDLE:
  - Queue non-empty: go to W_SRC.
  - Masked size (desc_size & ~3) is 0: go directly to POP instead; no engine access.
- Write states, one cycle each, reg_write=1:
  - W_SRC: addr 0, data src.
  - W_DST: addr 1, data dest.
  - W_SIZE: addr 4, data size & ~3.
  - W_TAIL: addr 2, data 0.
  - W_HEAD: addr 3, data size & ~3.
  - W_CTRL: addr 5, data 32'h1.
- Latency: a job accepted at edge k with the queue empty and FSM in IDLE gives reg_write high in the cycle after edge k+1. The six writes are back-to-back, ending at edge k+7.
- WAIT:
  - reg_write=0, reg_addr=5.
  - Leave to CLR on the first cycle with dma_intr=1 and reg_rdata[31]=1.
- dma_intr in any state other than WAIT is ignored.
- CLR: one-cycle write of addr 5, data 0 (clears INTR and EN).
- POP: dequeue the head, done_cnt+1 (16-bit wrap from 65535 to 0), return to IDLE.
- Minimum turnaround between jobs is one IDLE cycle.
- busy=1 in every state except IDLE.
- When no write is active, reg_wdata=0 and reg_addr holds the state's index (IDLE: 0).
- Reset mid-job: FSM returns to IDLE and the queue is flushed. The engine is reset by the same signal; no clean-up writes are issued.

Optional Feature:
- Macro: DMA_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT and clears on WAIT entry.
  - If it reaches TIMEOUT_CYCLES without an interrupt, the FSM goes to CLR then POP. err is set sticky until reset, and done_cnt is NOT incremented for that job.
- Undefined: no counter, WAIT is unbounded, err tied to 0.

Test Plan:
- Reset, then one job (src=0x1000, dest=0x2000, size=0x40): six writes in order (0:0x1000, 1:0x2000, 4:0x40, 2:0, 3:0x40, 5:0x1); first write in the cycle after edge k+1; interrupt with rdata[31]=1 → write 5:0, done_cnt=1, busy=0.
- Push 5 jobs back-to-back with no interrupts: desc_ready drops after the 4th accept, q_level=4; after one interrupt/retire, desc_ready=1 and the 5th is accepted.
- Job with size=0x3: no reg_write issued, done_cnt increments, FSM returns to IDLE within 2 cycles.
- dma_intr pulsed during W_DST and while rdata[31]=0 in WAIT: ignored; FSM stays in WAIT until intr=1 and rdata[31]=1.
- Assert M_AXI_ARESET while in WAIT with 3 jobs queued: next cycle state=IDLE, q_level=0, done_cnt=0, desc_ready=1.
- With DMA_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16: withhold the interrupt → clear write at ~16 cycles into WAIT, err=1, done_cnt unchanged, next job starts.
